// File: rtl/dram_pkg.sv
// Shared definitions for the 68000 DRAM controller: FSM state encoding and
// parameter defaults used by the controller and its refresh timer.
package dram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAS,
        CAS,
        HOLD,
        PRE,
        RCAS,
        RRAS
    } state_t;

    localparam int DEF_COLW   = 10;
    localparam int DEF_ROWW   = 10;
    localparam int DEF_NBANK  = 2;
    localparam int DEF_AW     = 21;
    localparam int DEF_RAW    = 12;
    localparam int DEF_TRAS   = 2;
    localparam int DEF_TRP    = 1;
    localparam int DEF_REFDIV = 250;
    localparam int DEF_URGTHR = 2;
    localparam int DEF_CBR    = 0;

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh tick divider plus the saturating pending-refresh counter and its
// urgency threshold compare.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int REFDIV = DEF_REFDIV,
    parameter int URGTHR = DEF_URGTHR
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       refAck,
    output logic [1:0] RefPend,
    output logic       urgent
);

    localparam int TW = (REFDIV > 1) ? $clog2(REFDIV) : 1;

    logic [TW-1:0] timer;
    logic          tick;

    assign tick   = (timer == TW'(REFDIV - 1));
    assign urgent = (RefPend >= 2'(URGTHR));

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            timer   <= '0;
            RefPend <= 2'd0;
        end else begin
            timer <= tick ? '0 : timer + TW'(1);
            // A tick and an acknowledge in the same clock cancel out.
            case ({tick, refAck})
                2'b10: if (RefPend != 2'd3) RefPend <= RefPend + 2'd1;
                2'b01: RefPend <= RefPend - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dram_ctrl.sv
// 68000-bus DRAM controller: one RAS/CAS access per bus cycle, RAS-only or
// CAS-before-RAS refresh, registered strobes that change together with the state.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int COLW   = DEF_COLW,
    parameter int ROWW   = DEF_ROWW,
    parameter int NBANK  = DEF_NBANK,
    parameter int AW     = DEF_AW,
    parameter int RAW    = DEF_RAW,
    parameter int TRAS   = DEF_TRAS,
    parameter int TRP    = DEF_TRP,
    parameter int REFDIV = DEF_REFDIV,
    parameter int URGTHR = DEF_URGTHR,
    parameter int CBR    = DEF_CBR
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic [AW:1]      A,
    input  logic             nWE,
    input  logic             nAS,
    input  logic             nLDS,
    input  logic             nUDS,
    input  logic             BACT,
    input  logic             RAMCS,
    output logic             RAM_Ready,
    output logic [RAW-1:0]   RA,
    output logic [NBANK-1:0] nRAS,
    output logic             nCAS,
    output logic             nLWE,
    output logic             nUWE,
    output logic             nOE,
    output logic [1:0]       RefPend
);

    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

    state_t          state;
    logic [2:0]      dly;
    logic [ROWW-1:0] refRow;
    logic            accDone;
    logic            urgent;
    logic            goRef;
    logic            goAcc;
    logic            refAck;
    logic            casPhase;
    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;
    logic [BW-1:0]   bank;
    logic [NBANK-1:0] bankSel;
    logic [RAW-1:0]  rowPad;
    logic [RAW-1:0]  colPad;
    logic [RAW-1:0]  refPad;

    assign col = A[COLW:1];
    assign row = A[COLW+ROWW:COLW+1];

    generate
        if (NBANK > 1) begin : gBank
            assign bank = A[AW:COLW+ROWW+1];
        end else begin : gNoBank
            assign bank = '0;
        end
    endgenerate

    always_comb begin
        bankSel = '0;
        for (int i = 0; i < NBANK; i++) bankSel[i] = (bank == BW'(i));
        rowPad = '0;
        rowPad[ROWW-1:0] = row;
        colPad = '0;
        colPad[COLW-1:0] = col;
        refPad = '0;
        refPad[ROWW-1:0] = refRow;
    end

    // IDLE arbitration: urgent refresh beats a RAM request, which beats a lazy refresh.
    assign goRef  = urgent || (RefPend != 2'd0 && !(BACT && RAMCS));
    assign goAcc  = BACT && RAMCS && !accDone;
    assign refAck = (state == IDLE && goRef && CBR == 0) || (state == RCAS);

    // RAM_Ready is the only handshake: while RAMCS is high the CPU cycle stalls
    // until the access reaches HOLD; non-RAM cycles are never held off.
    assign casPhase  = (state == CAS) || (state == HOLD);
    assign RAM_Ready = !RAMCS || (state == HOLD);
    assign nOE       = !(nWE && !nAS && casPhase);
    assign nLWE      = !(!nWE && !nLDS && casPhase);
    assign nUWE      = !(!nWE && !nUDS && casPhase);

    dram_refresh_timer #(
        .REFDIV(REFDIV),
        .URGTHR(URGTHR)
    ) uRefresh (
        .CLK    (CLK),
        .nRESET (nRESET),
        .refAck (refAck),
        .RefPend(RefPend),
        .urgent (urgent)
    );

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state   <= IDLE;
            nRAS    <= '1;
            nCAS    <= 1'b1;
            RA      <= '0;
            dly     <= 3'd0;
            refRow  <= '0;
            accDone <= 1'b0;
        end else begin
            // Blocks a second access while the same bus cycle is still active.
            if (state == HOLD && !BACT) accDone <= 1'b1;
            else if (!BACT)             accDone <= 1'b0;

            case (state)
                IDLE: begin
                    if (goRef) begin
                        if (CBR != 0) begin
                            state <= RCAS;
                            nCAS  <= 1'b0;
                        end else begin
                            state <= RRAS;
                            nRAS  <= '0;
                            RA    <= refPad;
                            dly   <= 3'(TRAS - 1);
                        end
                    end else if (goAcc) begin
                        state <= RAS;
                        nRAS  <= ~bankSel;
                        RA    <= rowPad;
                    end
                end
                RAS: begin
                    state <= CAS;
                    nCAS  <= 1'b0;
                    RA    <= colPad;
                end
                CAS: state <= HOLD;
                HOLD: begin
                    if (!BACT) begin
                        state <= PRE;
                        nRAS  <= '1;
                        nCAS  <= 1'b1;
                        dly   <= 3'(TRP - 1);
                    end
                end
                RCAS: begin
                    state <= RRAS;
                    nRAS  <= '0;
                    dly   <= 3'(TRAS - 1);
                end
                RRAS: begin
                    if (dly == 3'd0) begin
                        state  <= PRE;
                        nRAS   <= '1;
                        nCAS   <= 1'b1;
                        refRow <= refRow + ROWW'(1);
                        dly    <= 3'(TRP - 1);
                    end else begin
                        dly <= dly - 3'd1;
                    end
                end
                PRE: begin
                    if (dly == 3'd0) state <= IDLE;
                    else             dly   <= dly - 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: a cycle model of the access/refresh protocol checked on
// every falling edge, plus directed literal checks on key timing points.
module tb_dram_ctrl;

    localparam int COLW = 10, ROWW = 10, NBANK = 2, AW = 21, RAW = 12;
    localparam int TRAS = 2, TRP = 1, REFDIV = 8, URGTHR = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          nRESET;
    logic [AW:1]   A;
    logic          nWE, nAS, nLDS, nUDS, BACT, RAMCS;
    logic          RAM_Ready, nCAS, nLWE, nUWE, nOE;
    logic [RAW-1:0] RA;
    logic [1:0]    nRAS, RefPend;

    // CAS-before-RAS instance, bus kept idle
    logic [AW:1]   cbrA;
    logic          cbrReady, cbrCas, cbrLwe, cbrUwe, cbrOe;
    logic [RAW-1:0] cbrRa;
    logic [1:0]    cbrRas, cbrPend;

    dram_ctrl #(.COLW(COLW), .ROWW(ROWW), .NBANK(NBANK), .AW(AW), .RAW(RAW), .TRAS(TRAS),
                .TRP(TRP), .REFDIV(REFDIV), .URGTHR(URGTHR), .CBR(0)) dut (
        .CLK(CLK), .nRESET(nRESET), .A(A), .nWE(nWE), .nAS(nAS), .nLDS(nLDS), .nUDS(nUDS),
        .BACT(BACT), .RAMCS(RAMCS), .RAM_Ready(RAM_Ready), .RA(RA), .nRAS(nRAS), .nCAS(nCAS),
        .nLWE(nLWE), .nUWE(nUWE), .nOE(nOE), .RefPend(RefPend)
    );

    dram_ctrl #(.COLW(COLW), .ROWW(ROWW), .NBANK(NBANK), .AW(AW), .RAW(RAW), .TRAS(TRAS),
                .TRP(TRP), .REFDIV(REFDIV), .URGTHR(URGTHR), .CBR(1)) dutCbr (
        .CLK(CLK), .nRESET(nRESET), .A(cbrA), .nWE(1'b1), .nAS(1'b1), .nLDS(1'b1), .nUDS(1'b1),
        .BACT(1'b0), .RAMCS(1'b0), .RAM_Ready(cbrReady), .RA(cbrRa), .nRAS(cbrRas), .nCAS(cbrCas),
        .nLWE(cbrLwe), .nUWE(cbrUwe), .nOE(cbrOe), .RefPend(cbrPend)
    );

    int checks = 0;
    int errors = 0;
    bit chkEn = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        @(negedge CLK);
    endtask

    // ---------------- behavioural model ----------------
    // mKind: 0 idle, 1 access (mAge counts clocks since row strobe), 2 refresh, 3 precharge
    int mKind, mAge, mPend, mTimer, mRow;
    bit mDone, mTick, mStartRef, mHoldExit;

    always @(posedge CLK) begin
        if (!nRESET) begin
            mKind = 0; mAge = 0; mPend = 0; mTimer = 0; mRow = 0; mDone = 0;
        end else begin
            mTick = (mTimer == REFDIV - 1);
            mTimer = mTick ? 0 : mTimer + 1;
            mStartRef = 0;
            mHoldExit = 0;
            case (mKind)
                0: begin
                    if (mPend >= URGTHR || (mPend != 0 && !(BACT && RAMCS))) begin
                        mStartRef = 1; mKind = 2; mAge = 0;
                    end else if (BACT && RAMCS && !mDone) begin
                        mKind = 1; mAge = 0;
                    end
                end
                1: begin
                    if (mAge < 2) mAge++;
                    else if (!BACT) begin mHoldExit = 1; mKind = 3; mAge = 0; end
                end
                2: begin
                    if (mAge == TRAS - 1) begin
                        mKind = 3; mAge = 0; mRow = (mRow + 1) % (1 << ROWW);
                    end else mAge++;
                end
                default: begin
                    if (mAge == TRP - 1) mKind = 0;
                    else mAge++;
                end
            endcase
            if (mTick && !mStartRef) mPend = (mPend == 3) ? 3 : mPend + 1;
            else if (!mTick && mStartRef) mPend--;
            if (mHoldExit) mDone = 1;
            else if (!BACT) mDone = 0;
        end
    end

    int cAddr, cBank, cRow, cCol;
    logic [1:0] eRas, one2;
    logic eCas, eCasPhase, eReady, raValid;
    logic [RAW-1:0] eRa;

    always @(negedge CLK) begin
        if (chkEn) begin
            cAddr = int'(A);
            cCol  = cAddr % (1 << COLW);
            cRow  = (cAddr >> COLW) % (1 << ROWW);
            cBank = cAddr >> (COLW + ROWW);
            one2 = 2'b01;
            eRas = 2'b11; eCas = 1'b1; eCasPhase = 1'b0; raValid = 1'b0; eRa = '0;
            if (mKind == 1) begin
                eRas = ~(one2 << cBank);
                eCasPhase = (mAge >= 1);
                eCas = !eCasPhase;
                eRa = eCasPhase ? RAW'(cCol) : RAW'(cRow);
                raValid = 1'b1;
            end else if (mKind == 2) begin
                eRas = 2'b00;
                eRa = RAW'(mRow);
                raValid = 1'b1;
            end
            eReady = !RAMCS || (mKind == 1 && mAge >= 2);
            check("cmp_nRAS", nRAS, eRas);
            check("cmp_nCAS", nCAS, eCas);
            check("cmp_RAM_Ready", RAM_Ready, eReady);
            check("cmp_RefPend", RefPend, mPend);
            check("cmp_nOE", nOE, !(nWE && !nAS && eCasPhase));
            check("cmp_nLWE", nLWE, !(!nWE && !nLDS && eCasPhase));
            check("cmp_nUWE", nUWE, !(!nWE && !nUDS && eCasPhase));
            if (raValid) check("cmp_RA", RA, eRa);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic busIdle();
        nWE = 1; nAS = 1; nLDS = 1; nUDS = 1; BACT = 0; RAMCS = 0;
    endtask

    task automatic doReset();
        nRESET = 0;
        step(2);
        check("reset_nRAS", nRAS, 2'b11);
        check("reset_nCAS", nCAS, 1);
        check("reset_RefPend", RefPend, 0);
        check("reset_cbr_nRAS", cbrRas, 2'b11);
        chkEn = 1;
        nRESET = 1;
    endtask

    task automatic waitReady(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (RAM_Ready === 1'b1) begin ok = 1; break; end
        end
        check(name, ok, 1);
    endtask

    int maxPend, refCycles;
    bit sawRef;

    initial begin
        cbrA = '0;
        A = '0;
        busIdle();

        // refresh rows with idle bus, and CBR ordering on the second instance
        doReset();
        step(9);
        check("ref0_nRAS", nRAS, 2'b00);
        check("ref0_RA", RA, 0);
        check("cbr_rcas_nCAS", cbrCas, 0);
        check("cbr_rcas_nRAS", cbrRas, 2'b11);
        step(1);
        check("ref0b_nRAS", nRAS, 2'b00);
        check("cbr_rras_nRAS", cbrRas, 2'b00);
        check("cbr_rras_nCAS", cbrCas, 0);
        step(7);
        check("ref1_RA", RA, 1);
        step(8);
        check("ref2_RA", RA, 2);
        step(8 * 1021);
        check("ref1023_RA", RA, 1023);
        step(8);
        check("refwrap_RA", RA, 0);
        check("refwrap_nRAS", nRAS, 2'b00);

        // read right after reset: row strobe, column strobe, ready on clocks 1..3
        doReset();
        A = {1'b0, 10'h155, 10'h0AA};
        nWE = 1; nAS = 0; nLDS = 0; nUDS = 0; BACT = 1; RAMCS = 1;
        step(1);
        check("rd_ras_nRAS", nRAS, 2'b10);
        check("rd_ras_RA", RA, 12'h155);
        check("rd_ras_ready", RAM_Ready, 0);
        step(1);
        check("rd_cas_nCAS", nCAS, 0);
        check("rd_cas_RA", RA, 12'h0AA);
        check("rd_cas_nOE", nOE, 0);
        step(1);
        check("rd_hold_ready", RAM_Ready, 1);
        step(2);
        busIdle();
        step(1);
        check("rd_pre_nRAS", nRAS, 2'b11);
        check("rd_pre_nCAS", nCAS, 1);
        step(3);

        // upper-byte write to bank 1
        A = {1'b1, 10'h3C3, 10'h21F};
        nWE = 0; nAS = 0; nUDS = 0; nLDS = 1; BACT = 1; RAMCS = 1;
        sawRef = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (nRAS === 2'b01) begin sawRef = 1; break; end
        end
        check("wr_bank1_ras", sawRef, 1);
        check("wr_ras_RA", RA, 12'h3C3);
        step(1);
        check("wr_cas_RA", RA, 12'h21F);
        check("wr_cas_nUWE", nUWE, 0);
        check("wr_cas_nLWE", nLWE, 1);
        step(1);
        check("wr_hold_ready", RAM_Ready, 1);
        check("wr_hold_nUWE", nUWE, 0);
        busIdle();
        step(3);

        // long non-RAM bus cycle: refresh keeps running, backlog stays shallow
        BACT = 1; RAMCS = 0; nAS = 0;
        maxPend = 0; refCycles = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (int'(RefPend) > maxPend) maxPend = int'(RefPend);
            if (nRAS === 2'b00) refCycles++;
        end
        check("nonram_maxPend", maxPend, 1);
        check("nonram_refreshed", refCycles > 0, 1);
        busIdle();
        step(2);

        // long access lets refresh back up; the next access waits behind urgent refreshes
        A = {1'b0, 10'h00F, 10'h3F0};
        nWE = 1; nAS = 0; BACT = 1; RAMCS = 1;
        waitReady("hold_wait");
        step(30);
        check("hold_pend_sat", RefPend, 3);
        BACT = 0; nAS = 1;
        step(2);
        BACT = 1; nAS = 0;
        sawRef = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (nRAS === 2'b00 && RAM_Ready === 1'b0) sawRef = 1;
            if (RAM_Ready === 1'b1) break;
        end
        check("urgent_ref_first", sawRef, 1);
        check("urgent_then_ready", RAM_Ready, 1);
        busIdle();
        step(3);

        // reset while in HOLD drops every strobe on that edge
        A = {1'b1, 10'h001, 10'h002};
        nWE = 1; nAS = 0; BACT = 1; RAMCS = 1;
        waitReady("rst_hold_wait");
        nRESET = 0;
        step(1);
        check("rsthold_nRAS", nRAS, 2'b11);
        check("rsthold_nCAS", nCAS, 1);
        check("rsthold_RefPend", RefPend, 0);
        check("rsthold_ready", RAM_Ready, 0);
        busIdle();
        nRESET = 1;
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
